thumb_inst_align: RTL and testbench
===================================

Name: thumb_inst_align

Overview:
- Fetch-side alignment stage directly upstream of the pre-decoder in arm_core.
- Accepts a stream of 16-bit halfwords from instruction memory and buffers them in a small halfword FIFO.
- Issues complete Thumb/Thumb-2 instructions (16- or 32-bit) on a registered valid/ready interface, each tagged with its halfword address.
- Supports a synchronous flush/redirect for branches.

Parameters:
- FIFO_DEPTH, 4: halfword buffer entries; legal range 2 to 16, power of two.
- ADDR_W, 32: width of the address carried with each instruction.

Ports:
- clk, input, 1: core clock; all state on rising edge.
- rst_n, input, 1: asynchronous, active-low reset.
- hw_in, input, 16: halfword from instruction memory.
- hw_valid, input, 1: hw_in is valid this cycle.
- hw_ready, output, 1: FIFO can accept; a transfer occurs when hw_valid and hw_ready are both high.
- flush, input, 1: discard all buffered and issued state and redirect.
- flush_addr, input, ADDR_W: address of the next halfword after a flush; bit 0 ignored.
- inst_out, output, 32: 32-bit instruction is {hw1,hw2}; 16-bit instruction is {hw,16'h0000} (opcode left-aligned, so IT appears as inst_out[31:24]==8'hbf).
- inst_is32, output, 1: inst_out is a 32-bit encoding.
- inst_addr, output, ADDR_W: address of the first halfword of inst_out.
- inst_valid, output, 1: inst_out, inst_is32 and inst_addr are valid.
- inst_ready, input, 1: downstream accepts; inst_out is consumed when inst_valid and inst_ready are both high.

Behaviour:
- Reset values: inst_out=0, inst_is32=0, inst_addr=0, inst_valid=0, FIFO count=0, fetch address=0. hw_ready rises on the first edge after reset release.
- 32-bit detection: the head halfword is 32-bit when hw[15:11] is 5'b11101, 5'b11110 or 5'b11111; otherwise it is 16-bit.
- hw_ready is high when count < FIFO_DEPTH, computed from registered count only. There is no same-cycle pop credit.
- Fetch address:
  - Each accepted halfword is stored with the current fetch address.
  - The fetch address then advances by 2 and wraps modulo 2^ADDR_W.
- Issue condition: the output register loads when both hold:
  - it is empty or being consumed this cycle;
  - the FIFO head forms a complete instruction: a 16-bit head needs count>=1, a 32-bit head needs count>=2.
- On load, 1 or 2 entries are popped. If the issue condition fails, inst_valid falls when the current instruction is consumed.
- Output hold: while inst_valid=1 and inst_ready=0, inst_out, inst_is32 and inst_addr are stable.
- Latency:
  - A halfword accepted at edge k, into an empty FIFO with an empty output, is visible on inst_out after edge k+1 if it is 16-bit.
  - For a 32-bit instruction, the output is valid one edge after the second halfword is accepted.
  - There is no combinational path from hw_in to inst_out.
- Simultaneous push and pop in one cycle are allowed; count updates by (push - pop).
- Partial 32-bit: a lone 32-bit prefix at the head with count==1 stalls issue indefinitely until its second halfword arrives. It is never issued alone.
- Flush (highest priority, synchronous):
  - On the edge with flush=1: count becomes 0, inst_valid becomes 0, and the fetch address loads {flush_addr[ADDR_W-1:1],1'b0}.
  - A halfword presented in the flush cycle is dropped.
  - A consumption by downstream in the flush cycle still counts as consumed.
- Reset mid-operation: asynchronous clear to the reset values; partial instructions are lost.
- FIFO pointers wrap modulo FIFO_DEPTH.
- Count width is clog2(FIFO_DEPTH)+1, so count==FIFO_DEPTH is representable.

Optional Feature:
- Macro: THUMB_ALIGN_PERF_CNT_EN.
- Defined:
  - Adds output ports perf_cnt16[31:0] and perf_cnt32[31:0].
  - Each counts 16-bit and 32-bit instructions consumed (inst_valid && inst_ready) respectively.
  - Both reset to 0, wrap at 2^32, and are not cleared by flush.
- Undefined: the ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- Shared package arm_if_pkg holds:
  - HW_W=16 and INST_W=32;
  - the three 32-bit prefix constants;
  - a function is_thumb32(hw) returning the prefix match, reused by the pre-decoder.
- One sub-module, hw_fifo:
  - parameterised depth and width; stores {addr,hw} per entry;
  - ports: push, pop1, pop2, head0, head1, count;
  - async active-low reset.
- Alignment, issue and flush control stay in thumb_inst_align.

Test Plan:
- Reset then a 16-bit stream 0x2001, 0x2102 with inst_ready=1 → inst_out=0x20010000 with addr 0x0, then 0x21020000 with addr 0x2, inst_is32=0.
- 32-bit pair 0xF04F, 0x0001 → exactly one issue: inst_out=0xF04F0001, inst_is32=1, addr 0x0. No output while only 0xF04F is buffered.
- Mixed stream 0xBF08, 0xF000, 0xB800, 0x4770 → issues 0xBF080000 (addr 0x0), 0xF000B800 (addr 0x2), 0x47700000 (addr 0x6).
- inst_ready=0 with 5 halfwords offered, FIFO_DEPTH=4 → hw_ready=0 after 4 accepts plus 1 held in the output; outputs stay stable; no loss or duplication after ready returns.
- Flush with flush_addr=0x100 while 0xF04F is buffered and hw_valid=1 → inst_valid=0 next edge; next halfword 0x2003 issues with addr 0x100; the dropped halfword never appears.
- With THUMB_ALIGN_PERF_CNT_EN defined and the mixed stream of the third scenario → perf_cnt16=2, perf_cnt32=1; a subsequent flush leaves the counters unchanged.

Source files
------------

// File: rtl/arm_if_pkg.sv
// Shared fetch/pre-decode definitions for arm_core.
// Halfword/instruction widths and the Thumb-2 32-bit prefix match.
package arm_if_pkg;

    localparam int HW_W   = 16;
    localparam int INST_W = 32;

    localparam logic [4:0] T32_PFX_0 = 5'b11101;
    localparam logic [4:0] T32_PFX_1 = 5'b11110;
    localparam logic [4:0] T32_PFX_2 = 5'b11111;

    function automatic logic is_thumb32(input logic [HW_W-1:0] hw);
        return (hw[15:11] == T32_PFX_0) ||
               (hw[15:11] == T32_PFX_1) ||
               (hw[15:11] == T32_PFX_2);
    endfunction

endpackage

// File: rtl/thumb_inst_align_if.sv
// Fetch-to-predecode bundle: halfword stream in, aligned instructions out.
// slave = the aligner, master = memory/pre-decoder side.
interface thumb_inst_align_if #(
    parameter int ADDR_W = 32
);
    import arm_if_pkg::*;

    logic [HW_W-1:0]   hw_in;
    logic              hw_valid;
    logic              hw_ready;
    logic              flush;
    logic [ADDR_W-1:0] flush_addr;
    logic [INST_W-1:0] inst_out;
    logic              inst_is32;
    logic [ADDR_W-1:0] inst_addr;
    logic              inst_valid;
    logic              inst_ready;

    modport slave (
        input  hw_in, hw_valid, flush, flush_addr, inst_ready,
        output hw_ready, inst_out, inst_is32, inst_addr, inst_valid
    );

    modport master (
        output hw_in, hw_valid, flush, flush_addr, inst_ready,
        input  hw_ready, inst_out, inst_is32, inst_addr, inst_valid
    );

endinterface

// File: rtl/hw_fifo.sv
// Small halfword FIFO with one- or two-entry pop and two-entry peek.
// Each entry holds {addr,hw}; clr empties it synchronously.
module hw_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 48
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   clr,
    input  logic                   push,
    input  logic [W-1:0]           wdata,
    input  logic                   pop1,
    input  logic                   pop2,
    output logic [W-1:0]           head0,
    output logic [W-1:0]           head1,
    output logic [$clog2(DEPTH):0] count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [1:0]    pop_n;

    assign pop_n = pop2 ? 2'd2 : (pop1 ? 2'd1 : 2'd0);
    assign head0 = mem[rd_ptr];
    assign head1 = mem[rd_ptr + PW'(1)];

    // Pointers wrap naturally at DEPTH (power of two); count tracks push-pop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (clr) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + PW'(1);
            rd_ptr <= rd_ptr + PW'(pop_n);
            count  <= count + CW'(push) - CW'(pop_n);
        end
    end

    // Entry storage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++)
                mem[i] <= '0;
        end else if (push) begin
            mem[wr_ptr] <= wdata;
        end
    end

endmodule

// File: rtl/thumb_inst_align.sv
// Thumb/Thumb-2 fetch alignment stage feeding the pre-decoder.
// Optional THUMB_ALIGN_PERF_CNT_EN adds consumed 16/32-bit counters.
module thumb_inst_align
    import arm_if_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int ADDR_W     = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    thumb_inst_align_if.slave  bus
`ifdef THUMB_ALIGN_PERF_CNT_EN
    ,
    output logic [31:0]        perf_cnt16,
    output logic [31:0]        perf_cnt32
`endif
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam int EW = ADDR_W + HW_W;
    localparam logic [CW-1:0] FULL = CW'(FIFO_DEPTH);
    localparam logic [CW-1:0] ONE  = CW'(1);
    localparam logic [CW-1:0] TWO  = CW'(2);

    logic              rdy_en;
    logic [ADDR_W-1:0] fetch_addr;
    logic [CW-1:0]     count;
    logic [EW-1:0]     head0;
    logic [EW-1:0]     head1;
    logic              push;
    logic              pop1;
    logic              pop2;
    logic              head_is32;
    logic              complete;
    logic              load;
    logic              consume;
    logic              unused_bits;

    logic [INST_W-1:0] inst_out_q;
    logic              inst_is32_q;
    logic [ADDR_W-1:0] inst_addr_q;
    logic              inst_valid_q;

    assign bus.hw_ready   = rdy_en && (count < FULL);
    assign bus.inst_out   = inst_out_q;
    assign bus.inst_is32  = inst_is32_q;
    assign bus.inst_addr  = inst_addr_q;
    assign bus.inst_valid = inst_valid_q;

    assign push      = bus.hw_valid && bus.hw_ready && !bus.flush;
    assign head_is32 = is_thumb32(head0[HW_W-1:0]);
    assign complete  = head_is32 ? (count >= TWO) : (count >= ONE);
    assign consume   = inst_valid_q && bus.inst_ready;
    assign load      = !bus.flush && (!inst_valid_q || bus.inst_ready) &&
                       complete;
    assign pop1      = load && !head_is32;
    assign pop2      = load && head_is32;

    assign unused_bits = ^{bus.flush_addr[0], head1[EW-1:HW_W]};

    hw_fifo #(
        .DEPTH (FIFO_DEPTH),
        .W     (EW)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (bus.flush),
        .push  (push),
        .wdata ({fetch_addr, bus.hw_in}),
        .pop1  (pop1),
        .pop2  (pop2),
        .head0 (head0),
        .head1 (head1),
        .count (count)
    );

    // Hold off hw_ready until the first edge after reset release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            rdy_en <= 1'b0;
        else
            rdy_en <= 1'b1;
    end

    // Fetch address: redirect on flush, else step one halfword per push.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            fetch_addr <= '0;
        else if (bus.flush)
            fetch_addr <= {bus.flush_addr[ADDR_W-1:1], 1'b0};
        else if (push)
            fetch_addr <= fetch_addr + ADDR_W'(2);
    end

    // Output register: flush kills, load refills, consume empties.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inst_out_q   <= '0;
            inst_is32_q  <= 1'b0;
            inst_addr_q  <= '0;
            inst_valid_q <= 1'b0;
        end else if (bus.flush) begin
            inst_valid_q <= 1'b0;
        end else if (load) begin
            inst_valid_q <= 1'b1;
            inst_is32_q  <= head_is32;
            inst_addr_q  <= head0[EW-1:HW_W];
            inst_out_q   <= head_is32 ?
                            {head0[HW_W-1:0], head1[HW_W-1:0]} :
                            {head0[HW_W-1:0], {HW_W{1'b0}}};
        end else if (consume) begin
            inst_valid_q <= 1'b0;
        end
    end

`ifdef THUMB_ALIGN_PERF_CNT_EN
    // Count consumed instructions by size; flush does not clear them.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_cnt16 <= '0;
            perf_cnt32 <= '0;
        end else if (consume) begin
            if (inst_is32_q)
                perf_cnt32 <= perf_cnt32 + 32'd1;
            else
                perf_cnt16 <= perf_cnt16 + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_thumb_inst_align.sv
// Scoreboard bench for thumb_inst_align: directed scenarios + random traffic.
// Expected instructions come from a halfword-queue reference model.
module tb_thumb_inst_align;
    import arm_if_pkg::*;

    localparam int DEPTH = 4;
    localparam int AW    = 32;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    thumb_inst_align_if #(.ADDR_W(AW)) bus();

`ifdef THUMB_ALIGN_PERF_CNT_EN
    logic [31:0] perf_cnt16;
    logic [31:0] perf_cnt32;
`endif

    thumb_inst_align #(
        .FIFO_DEPTH (DEPTH),
        .ADDR_W     (AW)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .bus        (bus)
`ifdef THUMB_ALIGN_PERF_CNT_EN
        ,
        .perf_cnt16 (perf_cnt16),
        .perf_cnt32 (perf_cnt32)
`endif
    );

    typedef struct packed {
        logic [31:0]   inst;
        logic          is32;
        logic [AW-1:0] addr;
    } exp_t;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [15:0]   hw;
    } pend_t;

    int checks = 0;
    int errors = 0;
    int n_consumed = 0;

    exp_t          exp_q[$];
    pend_t         pend_q[$];
    logic [AW-1:0] m_addr = '0;

    // Reference: any halfword whose top three bits are all ones, except
    // 111_00 (unconditional branch), opens a 32-bit instruction.
    function automatic bit is32_ref(logic [15:0] h);
        return (h[15:13] == 3'b111) && (h[12:11] != 2'b00);
    endfunction

    task automatic check(string name, logic [63:0] act, logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Turn buffered halfwords into whole expected instructions, in order.
    function automatic void parse();
        exp_t e;
        while (pend_q.size() > 0) begin
            if (is32_ref(pend_q[0].hw)) begin
                if (pend_q.size() < 2)
                    break;
                e.inst = {pend_q[0].hw, pend_q[1].hw};
                e.is32 = 1'b1;
                e.addr = pend_q[0].addr;
                void'(pend_q.pop_front());
                void'(pend_q.pop_front());
            end else begin
                e.inst = {pend_q[0].hw, 16'h0000};
                e.is32 = 1'b0;
                e.addr = pend_q[0].addr;
                void'(pend_q.pop_front());
            end
            exp_q.push_back(e);
        end
    endfunction

    // Monitor: samples 1 time unit before each rising edge.
    initial begin
        logic          have_prev;
        logic          prev_hold;
        logic [31:0]   prev_out;
        logic          prev_is32;
        logic [AW-1:0] prev_addr;
        exp_t          e;
        have_prev = 1'b0;
        prev_hold = 1'b0;
        prev_out  = '0;
        prev_is32 = 1'b0;
        prev_addr = '0;
        forever begin
            @(negedge clk);
            #4;
            if (!rst_n) begin
                pend_q.delete();
                exp_q.delete();
                m_addr    = '0;
                have_prev = 1'b0;
            end else begin
                if (have_prev && prev_hold) begin
                    check("hold_valid", bus.inst_valid, 1);
                    check("hold_out", bus.inst_out, prev_out);
                    check("hold_is32", bus.inst_is32, prev_is32);
                    check("hold_addr", bus.inst_addr, prev_addr);
                end
                if (bus.inst_valid && bus.inst_ready) begin
                    n_consumed++;
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_issue actual=%0h required=none",
                                 bus.inst_out);
                    end else begin
                        e = exp_q.pop_front();
                        check("issue_inst", bus.inst_out, e.inst);
                        check("issue_is32", bus.inst_is32, e.is32);
                        check("issue_addr", bus.inst_addr, e.addr);
                    end
                end
                if (bus.flush) begin
                    pend_q.delete();
                    exp_q.delete();
                    m_addr = {bus.flush_addr[AW-1:1], 1'b0};
                end else if (bus.hw_valid && bus.hw_ready) begin
                    pend_q.push_back({m_addr, bus.hw_in});
                    m_addr = m_addr + AW'(2);
                    parse();
                end
                have_prev = 1'b1;
                prev_hold = bus.inst_valid && !bus.inst_ready && !bus.flush;
                prev_out  = bus.inst_out;
                prev_is32 = bus.inst_is32;
                prev_addr = bus.inst_addr;
            end
        end
    end

    task automatic cyc();
        @(negedge clk);
        #1;
    endtask

    task automatic send(logic [15:0] h);
        int n;
        n = 0;
        bus.hw_in    = h;
        bus.hw_valid = 1'b1;
        while (!bus.hw_ready && n < 100) begin
            cyc();
            n++;
        end
        if (!bus.hw_ready) begin
            checks++;
            errors++;
            $display("FAIL send_timeout actual=stalled required=accept hw=%0h", h);
        end
        cyc();
        bus.hw_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        bus.hw_valid   = 1'b0;
        bus.flush      = 1'b0;
        bus.inst_ready = 1'b1;
        while ((exp_q.size() != 0 || bus.inst_valid) && n < 200) begin
            cyc();
            n++;
        end
        check("drain_empty", 64'(exp_q.size()), 0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        cyc();
        cyc();
        rst_n = 1'b1;
        cyc();
    endtask

    initial begin
        logic [31:0] held;
        int          c0;
        bus.hw_in      = '0;
        bus.hw_valid   = 1'b0;
        bus.flush      = 1'b0;
        bus.flush_addr = '0;
        bus.inst_ready = 1'b0;
        cyc();
        cyc();
        check("rst_valid", bus.inst_valid, 0);
        check("rst_out", bus.inst_out, 0);
        check("rst_addr", bus.inst_addr, 0);
        check("rst_is32", bus.inst_is32, 0);
        check("rst_hw_ready", bus.hw_ready, 0);
        rst_n = 1'b1;
        check("hw_ready_pre_edge", bus.hw_ready, 0);
        cyc();
        check("hw_ready_post_edge", bus.hw_ready, 1);

        // 16-bit stream and issue latency
        bus.inst_ready = 1'b1;
        send(16'h2001);
        check("lat16_early", bus.inst_valid, 0);
        cyc();
        check("lat16_valid", bus.inst_valid, 1);
        check("lat16_out", bus.inst_out, 32'h2001_0000);
        check("lat16_addr", bus.inst_addr, 0);
        send(16'h2102);
        drain();

        // 32-bit pair; lone prefix must not issue
        do_reset();
        send(16'hF04F);
        for (int i = 0; i < 4; i++) begin
            cyc();
            check("lone_prefix", bus.inst_valid, 0);
        end
        send(16'h0001);
        check("t32_early", bus.inst_valid, 0);
        cyc();
        check("t32_valid", bus.inst_valid, 1);
        check("t32_out", bus.inst_out, 32'hF04F_0001);
        check("t32_is32", bus.inst_is32, 1);
        check("t32_addr", bus.inst_addr, 0);
        drain();

        // Mixed stream
        do_reset();
        send(16'hBF08);
        send(16'hF000);
        send(16'hB800);
        send(16'h4770);
        drain();
`ifdef THUMB_ALIGN_PERF_CNT_EN
        check("perf16", perf_cnt16, 2);
        check("perf32", perf_cnt32, 1);
        bus.flush      = 1'b1;
        bus.flush_addr = 32'h40;
        cyc();
        bus.flush = 1'b0;
        cyc();
        check("perf16_flush", perf_cnt16, 2);
        check("perf32_flush", perf_cnt32, 1);
`endif

        // Backpressure: 4 in FIFO + 1 in output
        do_reset();
        bus.inst_ready = 1'b0;
        c0 = n_consumed;
        for (int i = 0; i < 5; i++)
            send(16'h0010 + 16'(i));
        cyc();
        check("full_hw_ready", bus.hw_ready, 0);
        check("full_out", bus.inst_out, 32'h0010_0000);
        held = bus.inst_out;
        bus.hw_in    = 16'h0099;
        bus.hw_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cyc();
            check("full_stall_ready", bus.hw_ready, 0);
            check("full_stable", bus.inst_out, held);
        end
        bus.hw_valid = 1'b0;
        drain();
        check("full_consumed", 64'(n_consumed - c0), 5);

        // Flush while a prefix is buffered and a halfword is offered
        do_reset();
        bus.inst_ready = 1'b1;
        send(16'hF04F);
        bus.flush      = 1'b1;
        bus.flush_addr = 32'h101;
        bus.hw_in      = 16'h2777;
        bus.hw_valid   = 1'b1;
        cyc();
        bus.flush    = 1'b0;
        bus.hw_valid = 1'b0;
        check("flush_valid", bus.inst_valid, 0);
        send(16'h2003);
        cyc();
        check("flush_issue_valid", bus.inst_valid, 1);
        check("flush_issue_out", bus.inst_out, 32'h2003_0000);
        check("flush_issue_addr", bus.inst_addr, 32'h100);
        drain();

        // Random traffic with occasional flushes and one async reset
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            if ($urandom % 5 < 2)
                bus.hw_in = {5'(5'd29 + 5'($urandom % 3)), 11'($urandom)};
            else
                bus.hw_in = 16'($urandom);
            bus.hw_valid   = ($urandom % 4) != 0;
            bus.inst_ready = ($urandom % 4) != 0;
            bus.flush      = ($urandom % 50) == 0;
            bus.flush_addr = $urandom;
            if (i == 1500) begin
                #2;
                rst_n = 1'b0;
                #1;
                check("async_rst_valid", bus.inst_valid, 0);
                check("async_rst_out", bus.inst_out, 0);
                cyc();
                rst_n = 1'b1;
            end
            cyc();
        end
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog");
    end

endmodule
